// File: rtl/miner_pkg.sv
// Shared definitions for the miner datapath: TX_ID geometry and the
// collector state encoding.
package miner_pkg;

    localparam int TX_ID_WIDTH       = 256;
    localparam int MAX_TX_ID_DEFAULT = 4;
    localparam int TX_BUS_WIDTH      = TX_ID_WIDTH * MAX_TX_ID_DEFAULT;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } collector_state_t;

endpackage

// File: rtl/tx_id_collector_if.sv
// Byte-stream input and packed TX_ID output bundle of the collector.
// The slave modport is the collector side; master is the upstream/consumer side.
interface tx_id_collector_if
    import miner_pkg::*;
#(
    parameter int MAX_TX_ID = MAX_TX_ID_DEFAULT
);
    logic [7:0]                         rx_data;
    logic                               rx_valid;
    logic [MAX_TX_ID*TX_ID_WIDTH-1:0]   TX_ID_input;
    logic [7:0]                         total_TX_ID;
    logic                               TX_ID_valid;
    logic                               busy;
    logic                               frame_error;

    modport slave (
        input  rx_data, rx_valid,
        output TX_ID_input, total_TX_ID, TX_ID_valid, busy, frame_error
    );

    modport master (
        output rx_data, rx_valid,
        input  TX_ID_input, total_TX_ID, TX_ID_valid, busy, frame_error
    );
endinterface

// File: rtl/byte_timeout_timer.sv
// Idle-cycle counter between received bytes; expired is high in the cycle
// the count reaches its limit, so a byte arriving that same cycle still wins.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [31:0] LIMIT = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (clear) begin
            r_cnt <= 32'd0;
        end else if (enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Zero cycles means the timeout is disabled entirely.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (r_cnt == LIMIT);

endmodule

// File: rtl/tx_id_collector.sv
// Collects a count byte plus N 32-byte transaction IDs into the packed
// TX_ID bus and pulses TX_ID_valid when a well-formed frame completes.
module tx_id_collector
    import miner_pkg::*;
#(
    parameter int MAX_TX_ID      = MAX_TX_ID_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    tx_id_collector_if.slave   bus
);
    localparam int BUS_W = MAX_TX_ID * TX_ID_WIDTH;
    localparam int IDX_W = $clog2(BUS_W);

    collector_state_t  r_state;
    logic [7:0]        r_n;
    logic [7:0]        r_bidx;
    logic [BUS_W-1:0]  r_asm;
    logic [BUS_W-1:0]  r_txid;
    logic [7:0]        r_total;
    logic              r_tx_valid;
    logic              r_err;

    logic [BUS_W-1:0]  w_asm_next;
    logic [IDX_W-1:0]  w_msb;
    logic              w_last;
    logic              w_count_ok;
    logic              w_expired;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.rx_valid || (r_state != RECV)),
        .enable  (r_state == RECV),
        .expired (w_expired)
    );

    // Hash slot in the upper counter bits, byte-in-hash in the low five; first byte is the MSB.
    assign w_msb      = IDX_W'({r_bidx[7:5], 8'hFF}) - IDX_W'({r_bidx[4:0], 3'b000});
    assign w_last     = ({5'b0, r_bidx} == ({r_n, 5'b0} - 13'd1));
    assign w_count_ok = (bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_TX_ID));

    always_comb begin
        w_asm_next              = r_asm;
        w_asm_next[w_msb -: 8]  = bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (bus.rx_valid) begin
            if (r_state == IDLE) begin
                r_asm <= '0;
            end else begin
                r_asm <= w_asm_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_n        <= 8'd0;
            r_bidx     <= 8'd0;
            r_txid     <= '0;
            r_total    <= 8'd0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        if (w_count_ok) begin
                            r_n     <= bus.rx_data;
                            r_bidx  <= 8'd0;
                            r_state <= RECV;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.rx_valid) begin
                        if (w_last) begin
                            r_txid     <= w_asm_next;
                            r_total    <= r_n;
                            r_tx_valid <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_bidx <= r_bidx + 8'd1;
                        end
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.TX_ID_input = r_txid;
    assign bus.total_TX_ID = r_total;
    assign bus.TX_ID_valid = r_tx_valid;
    assign bus.frame_error = r_err;
    assign bus.busy        = (r_state == RECV);

endmodule

// File: tb/tb_tx_id_collector.sv
// Directed bench for tx_id_collector: framing, packing order, back-to-back
// frames, bad counts, timeout and its boundary, and reset mid-frame.
module tb_tx_id_collector;
    import miner_pkg::*;

    localparam logic [255:0] SEQ0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] SEQ1 = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
    localparam logic [255:0] SEQ2 = 256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
    localparam logic [255:0] SEQ3 = 256'h606162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_err    = 0;
    int   snap_valid;
    int   snap_err;

    tx_id_collector_if #(.MAX_TX_ID(4)) bus ();

    tx_id_collector #(
        .MAX_TX_ID      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.TX_ID_valid === 1'b1) n_valid++;
        if (bus.frame_error === 1'b1) n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [255:0] e0, input logic [255:0] e1,
                           input logic [255:0] e2, input logic [255:0] e3);
        chk({tag, ".slot0"}, bus.TX_ID_input[255:0],    e0);
        chk({tag, ".slot1"}, bus.TX_ID_input[511:256],  e1);
        chk({tag, ".slot2"}, bus.TX_ID_input[767:512],  e2);
        chk({tag, ".slot3"}, bus.TX_ID_input[1023:768], e3);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        chk_bus("reset", '0, '0, '0, '0);
        chk("reset.total", 256'(bus.total_TX_ID), 256'd0);
        chk("reset.valid", 256'(bus.TX_ID_valid), 256'd0);
        chk("reset.busy",  256'(bus.busy),        256'd0);
        chk("reset.err",   256'(bus.frame_error), 256'd0);
        rst = 1'b0;
        tick();

        // Single hash, bytes 0x00..0x1F.
        send(8'd1);
        chk("single.busy_after_count", 256'(bus.busy), 256'd1);
        for (int p = 0; p < 31; p++) send(8'(p));
        chk("single.no_early_valid", 256'(bus.TX_ID_valid), 256'd0);
        send(8'h1F);
        chk("single.valid", 256'(bus.TX_ID_valid), 256'd1);
        chk("single.total", 256'(bus.total_TX_ID), 256'd1);
        chk("single.busy",  256'(bus.busy),        256'd0);
        chk_bus("single", SEQ0, '0, '0, '0);
        tick();
        chk("single.valid_one_cycle", 256'(bus.TX_ID_valid), 256'd0);

        // Three hashes then an immediate back-to-back single.
        snap_valid = n_valid;
        send(8'd3);
        for (int h = 0; h < 3; h++)
            for (int p = 0; p < 32; p++) send(8'hA0 + 8'(h));
        chk("three.valid", 256'(bus.TX_ID_valid), 256'd1);
        chk("three.total", 256'(bus.total_TX_ID), 256'd3);
        chk_bus("three", {32{8'hA0}}, {32{8'hA1}}, {32{8'hA2}}, '0);
        send(8'd1);
        chk("b2b.busy", 256'(bus.busy), 256'd1);
        for (int p = 0; p < 32; p++) send(8'h55);
        chk("b2b.valid", 256'(bus.TX_ID_valid), 256'd1);
        chk("b2b.total", 256'(bus.total_TX_ID), 256'd1);
        chk_bus("b2b", {32{8'h55}}, '0, '0, '0);
        tick();
        chk("b2b.pulse_count", 256'(n_valid - snap_valid), 256'd2);

        // Bad count bytes.
        snap_valid = n_valid;
        snap_err   = n_err;
        send(8'h00);
        chk("badcnt0.err",  256'(bus.frame_error), 256'd1);
        chk("badcnt0.busy", 256'(bus.busy),        256'd0);
        send(8'h05);
        chk("badcnt5.err",  256'(bus.frame_error), 256'd1);
        chk("badcnt5.busy", 256'(bus.busy),        256'd0);
        tick();
        chk("badcnt.err_clears", 256'(bus.frame_error), 256'd0);
        chk("badcnt.err_count",  256'(n_err - snap_err),     256'd2);
        chk("badcnt.no_valid",   256'(n_valid - snap_valid), 256'd0);
        chk("badcnt.total",      256'(bus.total_TX_ID),      256'd1);
        chk_bus("badcnt", {32{8'h55}}, '0, '0, '0);

        // Timeout 16 cycles after the 10th byte.
        snap_err = n_err;
        send(8'd2);
        for (int i = 0; i < 10; i++) send(8'h11);
        repeat (15) tick();
        chk("tmo.no_early_err", 256'(bus.frame_error), 256'd0);
        chk("tmo.busy_before",  256'(bus.busy),        256'd1);
        tick();
        chk("tmo.err",  256'(bus.frame_error), 256'd1);
        chk("tmo.busy", 256'(bus.busy),        256'd0);
        tick();
        chk("tmo.err_one_cycle", 256'(bus.frame_error), 256'd0);
        chk("tmo.total_kept",    256'(bus.total_TX_ID), 256'd1);
        chk_bus("tmo.kept", {32{8'h55}}, '0, '0, '0);
        send(8'd1);
        for (int p = 0; p < 32; p++) send(8'h3C);
        chk("tmo.next_valid", 256'(bus.TX_ID_valid), 256'd1);
        chk_bus("tmo.next", {32{8'h3C}}, '0, '0, '0);
        chk("tmo.err_count", 256'(n_err - snap_err), 256'd1);

        // Byte on the final timeout cycle wins.
        snap_err = n_err;
        send(8'd1);
        for (int i = 0; i < 5; i++) send(8'h77);
        repeat (15) tick();
        send(8'h77);
        chk("edge.no_err", 256'(bus.frame_error), 256'd0);
        chk("edge.busy",   256'(bus.busy),        256'd1);
        for (int i = 0; i < 26; i++) send(8'h77);
        chk("edge.valid", 256'(bus.TX_ID_valid), 256'd1);
        chk_bus("edge", {32{8'h77}}, '0, '0, '0);
        tick();
        chk("edge.err_count", 256'(n_err - snap_err), 256'd0);

        // Reset in the middle of an N=4 frame, then a full N=4 frame.
        send(8'd4);
        for (int b = 0; b < 40; b++) send(8'(b));
        snap_valid = n_valid;
        snap_err   = n_err;
        rst = 1'b1;
        #1;
        chk_bus("rstmid", '0, '0, '0, '0);
        chk("rstmid.total", 256'(bus.total_TX_ID), 256'd0);
        chk("rstmid.busy",  256'(bus.busy),        256'd0);
        tick();
        tick();
        chk("rstmid.valid", 256'(bus.TX_ID_valid), 256'd0);
        chk("rstmid.err",   256'(bus.frame_error), 256'd0);
        rst = 1'b0;
        tick();
        chk("rstmid.no_pulses", 256'((n_valid - snap_valid) + (n_err - snap_err)), 256'd0);
        send(8'd4);
        for (int b = 0; b < 128; b++) send(8'(b));
        chk("full4.valid", 256'(bus.TX_ID_valid), 256'd1);
        chk("full4.total", 256'(bus.total_TX_ID), 256'd4);
        chk_bus("full4", SEQ0, SEQ1, SEQ2, SEQ3);
        tick();
        chk("full4.busy", 256'(bus.busy), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
